// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port, byte-enable-free sram between the instruction fetch
//   port (read-only) and the load/store port (read/write with byte strobes).
//   One transaction is in flight at a time. Reads take one cycle; full-word
//   stores write directly; partial stores are done as read-modify-write.
//
// Handshake: a request is accepted in the cycle where *_req_valid and
//   *_req_ready are both 1. Ready is only raised in IDLE, combinationally from
//   the valids, and only for the granted port. Request fields are sampled only
//   in the accept cycle. Responses are single-cycle *_rsp_valid pulses with no
//   backpressure; *_rsp_data holds its last value between pulses.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_req_*           fetch request (valid/ready/addr)
//   i_rsp_*           fetch response (valid pulse, data)
//   d_req_*           load/store request (valid/ready/we/addr/wdata/wstrb)
//   d_rsp_*           load/store response (valid pulse, load data or 0)
//   sram_*            single-port sram interface (1-cycle synchronous read)
module sram_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 262144,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_rsp_valid,
  output logic [XLEN-1:0] i_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_req_we,
  input  logic [AW-1:0]   d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic [SW-1:0]   d_req_wstrb,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_data,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [XLEN-1:0] sram_data_in,
  input  logic [XLEN-1:0] sram_data_out
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RSP = 2'd1,
    MERGE  = 2'd2,
    WR_ACK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = load/store port owns RD_RSP
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [XLEN-1:0] i_rsp_data_q, i_rsp_data_d;
  logic [XLEN-1:0] d_rsp_data_q, d_rsp_data_d;

  logic            d_win;
  logic            both_valid;
  logic [XLEN-1:0] merged;

  // d wins ties unless fetch has lost STARVE_LIMIT contested rounds in a row.
  assign both_valid = i_req_valid && d_req_valid;
  assign d_win      = d_req_valid && (!i_req_valid || (starve_q != CW'(STARVE_LIMIT)));

  // Strobed bytes from the latched store data, the rest from the word just read.
  always_comb begin
    merged = '0;
    for (int b = 0; b < SW; b++) begin
      merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : sram_data_out[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    starve_d     = starve_q;
    i_rsp_data_d = i_rsp_data_q;
    d_rsp_data_d = d_rsp_data_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_rsp_valid  = 1'b0;
    d_rsp_valid  = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = addr_q;
    sram_data_in = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          d_req_ready = 1'b1;
          sram_addr   = d_req_addr;
          owner_d     = 1'b1;
          if (both_valid) starve_d = starve_q + CW'(1);
          if (!d_req_we) begin
            state_d = RD_RSP;
          end else if (&d_req_wstrb) begin
            sram_we      = 1'b1;
            sram_data_in = d_req_wdata;
            state_d      = WR_ACK;
          end else if (|d_req_wstrb) begin
            // Read the old word now; the write happens in MERGE.
            addr_d  = d_req_addr;
            wdata_d = d_req_wdata;
            wstrb_d = d_req_wstrb;
            state_d = MERGE;
          end else begin
            state_d = WR_ACK;
          end
        end else if (i_req_valid) begin
          i_req_ready = 1'b1;
          sram_addr   = i_req_addr;
          owner_d     = 1'b0;
          starve_d    = '0;
          state_d     = RD_RSP;
        end
      end
      RD_RSP: begin
        if (owner_q) begin
          d_rsp_valid  = 1'b1;
          d_rsp_data_d = sram_data_out;
        end else begin
          i_rsp_valid  = 1'b1;
          i_rsp_data_d = sram_data_out;
        end
        state_d = IDLE;
      end
      MERGE: begin
        sram_we      = 1'b1;
        sram_addr    = addr_q;
        sram_data_in = merged;
        state_d      = WR_ACK;
      end
      WR_ACK: begin
        d_rsp_valid  = 1'b1;
        d_rsp_data_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data is shown in the pulse cycle and held afterwards.
  assign i_rsp_data = i_rsp_data_d;
  assign d_rsp_data = d_rsp_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      starve_q     <= '0;
      i_rsp_data_q <= '0;
      d_rsp_data_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      starve_q     <= starve_d;
      i_rsp_data_q <= i_rsp_data_d;
      d_rsp_data_q <= d_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic            clk;
  logic            rst;
  logic            i_req_valid, i_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic            i_rsp_valid;
  logic [XLEN-1:0] i_rsp_data;
  logic            d_req_valid, d_req_ready, d_req_we;
  logic [AW-1:0]   d_req_addr;
  logic [XLEN-1:0] d_req_wdata;
  logic [7:0]      d_req_wstrb;
  logic            d_rsp_valid;
  logic [XLEN-1:0] d_rsp_data;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [XLEN-1:0] sram_data_in, sram_data_out;

  int n_cmp = 0;
  int n_err = 0;

  sram_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram model: synchronous read, write on we, plus a write counter
  logic [XLEN-1:0] mem [0:DEPTH-1];
  logic            preload;
  int              wr_count = 0;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      mem[10'h10] <= 64'hDEADBEEF_CAFEF00D;
      mem[10'h30] <= 64'hFFFFFFFF_FFFFFFFF;
      mem[10'h40] <= 64'h0000_0000_0000_5A5A;
      mem[10'h50] <= 64'h01234567_89ABCDEF;
      sram_data_out <= '0;
    end else begin
      if (sram_we) begin
        mem[sram_addr] <= sram_data_in;
        wr_count <= wr_count + 1;
      end
      sram_data_out <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'b0, obs}, {63'b0, exp});
  endtask

  // issue a load in IDLE, check ready, then check the response one cycle later
  task automatic do_load(input logic [AW-1:0] a, input logic [63:0] exp, input string tag);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = a; d_req_wstrb = 8'h00;
    #1;
    chk1({tag, "_ready"}, d_req_ready, 1'b1);
    chk1({tag, "_rd_we"}, sram_we, 1'b0);
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    chk1({tag, "_rsp_valid"}, d_rsp_valid, 1'b1);
    chk({tag, "_rsp_data"}, d_rsp_data, exp);
  endtask

  logic [9:0] exp_i_order;
  int         wr_before;
  int         i_pulses, d_pulses;

  initial begin
    rst = 1'b1; preload = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0;
    d_req_wdata = '0; d_req_wstrb = '0;

    // reset state
    @(negedge clk); #1;
    chk1("rst_i_ready", i_req_ready, 1'b0);
    chk1("rst_d_ready", d_req_ready, 1'b0);
    chk1("rst_i_rsp_valid", i_rsp_valid, 1'b0);
    chk1("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("rst_i_rsp_data", i_rsp_data, 64'h0);
    chk("rst_d_rsp_data", d_rsp_data, 64'h0);
    chk1("rst_sram_we", sram_we, 1'b0);
    @(negedge clk);
    preload = 1'b0; rst = 1'b0;

    // fetch only from 0x10
    @(negedge clk);
    wr_before = wr_count;
    i_req_valid = 1'b1; i_req_addr = 10'h10;
    #1;
    chk1("fetch_i_ready", i_req_ready, 1'b1);
    chk1("fetch_d_ready", d_req_ready, 1'b0);
    chk("fetch_addr", {54'b0, sram_addr}, 64'h10);
    chk1("fetch_we", sram_we, 1'b0);
    @(negedge clk);
    i_req_valid = 1'b0; i_req_addr = 10'h3FF;
    #1;
    chk1("fetch_rsp_valid", i_rsp_valid, 1'b1);
    chk("fetch_rsp_data", i_rsp_data, 64'hDEADBEEF_CAFEF00D);
    chk1("fetch_d_rsp_quiet", d_rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk1("fetch_pulse_end", i_rsp_valid, 1'b0);
    chk("fetch_data_hold", i_rsp_data, 64'hDEADBEEF_CAFEF00D);
    chk("fetch_no_write", 64'(wr_count - wr_before), 64'd0);

    // full store to 0x20, then load back
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h20;
    d_req_wdata = 64'h11223344_55667788; d_req_wstrb = 8'hFF;
    #1;
    chk1("fst_ready", d_req_ready, 1'b1);
    chk1("fst_we", sram_we, 1'b1);
    chk("fst_addr", {54'b0, sram_addr}, 64'h20);
    chk("fst_din", sram_data_in, 64'h11223344_55667788);
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    chk1("fst_ack", d_rsp_valid, 1'b1);
    chk("fst_ack_data", d_rsp_data, 64'h0);
    chk1("fst_ack_we", sram_we, 1'b0);
    do_load(10'h20, 64'h11223344_55667788, "fst_rb");

    // partial store 0x0F over all-ones at 0x30; change request fields after accept
    @(negedge clk);
    wr_before = wr_count;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h30;
    d_req_wdata = 64'hAAAAAAAA_BBBBBBBB; d_req_wstrb = 8'h0F;
    #1;
    chk1("pst_ready", d_req_ready, 1'b1);
    chk1("pst_read_we", sram_we, 1'b0);
    @(negedge clk);
    d_req_valid = 1'b0; d_req_addr = 10'h0; d_req_wdata = '0; d_req_wstrb = 8'h00;
    #1;
    chk1("pst_merge_we", sram_we, 1'b1);
    chk("pst_merge_addr", {54'b0, sram_addr}, 64'h30);
    chk("pst_merge_din", sram_data_in, 64'hFFFFFFFF_BBBBBBBB);
    chk1("pst_merge_no_rsp", d_rsp_valid, 1'b0);
    chk("pst_data_hold", d_rsp_data, 64'h11223344_55667788);
    @(negedge clk); #1;
    chk1("pst_ack", d_rsp_valid, 1'b1);
    chk("pst_ack_data", d_rsp_data, 64'h0);
    chk1("pst_ack_we", sram_we, 1'b0);
    chk("pst_one_write", 64'(wr_count - wr_before), 64'd1);
    do_load(10'h30, 64'hFFFFFFFF_BBBBBBBB, "pst_rb");

    // contention: fetch 0x10 and load 0x20 held valid together
    exp_i_order = 10'b10_0001_0000;
    i_pulses = 0; d_pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 10'h10;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h20;
      #1;
      chk1($sformatf("arb%0d_i_ready", k), i_req_ready, exp_i_order[k]);
      chk1($sformatf("arb%0d_d_ready", k), d_req_ready, !exp_i_order[k]);
      @(negedge clk); #1;
      if (i_rsp_valid) i_pulses++;
      if (d_rsp_valid) d_pulses++;
      chk1($sformatf("arb%0d_i_rsp", k), i_rsp_valid, exp_i_order[k]);
      chk1($sformatf("arb%0d_d_rsp", k), d_rsp_valid, !exp_i_order[k]);
      if (exp_i_order[k]) chk($sformatf("arb%0d_i_data", k), i_rsp_data, 64'hDEADBEEF_CAFEF00D);
      else chk($sformatf("arb%0d_d_data", k), d_rsp_data, 64'h11223344_55667788);
    end
    chk("arb_i_pulses", 64'(i_pulses), 64'd2);
    chk("arb_d_pulses", 64'(d_pulses), 64'd8);
    @(negedge clk);
    i_req_valid = 1'b0; d_req_valid = 1'b0;

    // zero-strobe store to 0x40
    @(negedge clk);
    wr_before = wr_count;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h40;
    d_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; d_req_wstrb = 8'h00;
    #1;
    chk1("zst_ready", d_req_ready, 1'b1);
    chk1("zst_we", sram_we, 1'b0);
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    chk1("zst_ack", d_rsp_valid, 1'b1);
    chk1("zst_ack_we", sram_we, 1'b0);
    chk("zst_no_write", 64'(wr_count - wr_before), 64'd0);
    do_load(10'h40, 64'h5A5A, "zst_rb");

    // reset during MERGE of a partial store to 0x50
    @(negedge clk);
    wr_before = wr_count;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h50;
    d_req_wdata = 64'h0; d_req_wstrb = 8'h01;
    #1;
    chk1("rmw_ready", d_req_ready, 1'b1);
    @(negedge clk);
    d_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rmw_rst_we", sram_we, 1'b0);
    chk1("rmw_rst_d_rsp", d_rsp_valid, 1'b0);
    chk1("rmw_rst_i_rsp", i_rsp_valid, 1'b0);
    chk("rmw_rst_d_data", d_rsp_data, 64'h0);
    chk("rmw_rst_i_data", i_rsp_data, 64'h0);
    chk1("rmw_rst_d_ready", d_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rmw_post_d_rsp", d_rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk1("rmw_post2_d_rsp", d_rsp_valid, 1'b0);
    chk("rmw_no_write", 64'(wr_count - wr_before), 64'd0);
    do_load(10'h50, 64'h01234567_89ABCDEF, "rmw_rb");

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
